// File: rtl/stats_pkg.sv
// Shared types and widths for the window statistics sequencer and its variance datapath.
package stats_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int ACC_W     = 64;
  localparam int VAR_W     = 32;
  localparam int EXP_CLAMP = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SETTLE,
    CALC1,
    CALC2,
    EXP,
    OUT
  } state_t;

  // Exponent argument: negated, clamped, shifted variance as a signed Q8 value.
  function automatic logic [SAMPLE_W-1:0] exp_arg(input logic [VAR_W-1:0] v,
                                                  input int unsigned shift);
    logic [VAR_W-1:0]    s;
    logic [SAMPLE_W-1:0] t;
    s = v >> shift;
    if (s > VAR_W'(EXP_CLAMP)) s = VAR_W'(EXP_CLAMP);
    t = s[SAMPLE_W-1:0];
    return -t;
  endfunction

endpackage

// File: rtl/stats_var_calc.sv
// Two-stage mean/variance datapath: stage 1 registers the window averages on start,
// stage 2 forms the clamped variance combinationally while done is high.
module stats_var_calc
  import stats_pkg::*;
#(
  parameter int LOG2_WIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ACC_W-1:0]    acc_sum,
  input  logic [ACC_W-1:0]    acc_sum_sq,
  output logic                done,
  output logic [SAMPLE_W-1:0] mean,
  output logic [VAR_W-1:0]    variance
);

  logic [ACC_W-1:0] sum_sh;
  logic [ACC_W-1:0] sq_sh;
  logic [VAR_W-1:0] msq;
  logic [VAR_W-1:0] mean_sq;
  logic             unused_hi;

  assign sum_sh = acc_sum >> LOG2_WIN;
  assign sq_sh  = acc_sum_sq >> LOG2_WIN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      mean <= '0;
      msq  <= '0;
    end else begin
      done <= start;
      if (start) begin
        mean <= sum_sh[SAMPLE_W-1:0];
        msq  <= sq_sh[VAR_W-1:0];
      end
    end
  end

  // Truncation of the averages can make mean^2 exceed msq; report zero then.
  assign mean_sq  = VAR_W'(mean) * VAR_W'(mean);
  assign variance = (mean_sq > msq) ? '0 : (msq - mean_sq);

  assign unused_hi = ^{sum_sh[ACC_W-1:SAMPLE_W], sq_sh[ACC_W-1:VAR_W]};

endmodule

// File: rtl/stats_window_ctrl.sv
// Sequences one window of 2^LOG2_WIN samples into the sum/sum-sq accumulator, then reports mean and variance.
// Build with STATS_EXP_SCORE_EN to add the EXP state that scores the variance through the external exp unit.
module stats_window_ctrl
  import stats_pkg::*;
#(
  parameter int LOG2_WIN    = 4,
  parameter int VAR_SHIFT   = 4,
  parameter int EXP_LATENCY = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  output logic                acc_mode,
  output logic                acc_status,
  output logic [SAMPLE_W-1:0] acc_data,
  input  logic [ACC_W-1:0]    acc_sum,
  input  logic [ACC_W-1:0]    acc_sum_sq,
  output logic [SAMPLE_W-1:0] exp_in,
  input  logic [SAMPLE_W-1:0] exp_result,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [SAMPLE_W-1:0] r_mean,
  output logic [VAR_W-1:0]    r_var,
  output logic [SAMPLE_W-1:0] r_exp,
  output logic                busy
);

  localparam int            CW   = LOG2_WIN + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_WIN) - 1);

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cnt;
  logic                settle_2nd;
  logic                hs;
  logic                calc_start;
  logic                calc_done;
  logic [SAMPLE_W-1:0] calc_mean;
  logic [VAR_W-1:0]    calc_var;

  assign s_ready    = (state == ACCUM);
  assign hs         = s_valid && s_ready && !abort;
  assign busy       = (state != IDLE);
  assign r_valid    = (state == OUT);
  assign acc_mode   = !((state == IDLE) || (state == CLEAR));
  assign calc_start = (state == CALC1) && !abort;

`ifdef STATS_EXP_SCORE_EN
  localparam int ECW = $clog2(EXP_LATENCY + 1) + 1;

  logic [ECW-1:0] exp_cnt;
  logic           exp_last;

  assign exp_last = (exp_cnt == ECW'(EXP_LATENCY));
  assign exp_in   = (state == EXP) ? exp_arg(r_var, VAR_SHIFT) : '0;

  // exp_in is held steady for the whole EXP stay; the result is taken on its final cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_cnt <= '0;
      r_exp   <= '0;
    end else begin
      exp_cnt <= ((state == EXP) && !exp_last) ? exp_cnt + ECW'(1) : '0;
      if ((state == EXP) && exp_last && !abort) r_exp <= exp_result;
    end
  end
`else
  logic unused_exp;

  assign unused_exp = ^{exp_result, 32'(VAR_SHIFT), 32'(EXP_LATENCY)};
  assign exp_in     = '0;
  assign r_exp      = '0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start) state_next = CLEAR;
      CLEAR:  state_next = ACCUM;
      ACCUM:  if (hs && (cnt == LAST)) state_next = SETTLE;
      SETTLE: if (settle_2nd) state_next = CALC1;
      CALC1:  state_next = CALC2;
`ifdef STATS_EXP_SCORE_EN
      CALC2:  state_next = EXP;
      EXP:    if (exp_last) state_next = OUT;
`else
      CALC2:  state_next = OUT;
`endif
      OUT:    if (r_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // acc_data/acc_status are registered: the accumulator adds one cycle after the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      settle_2nd <= 1'b0;
      acc_status <= 1'b1;
      acc_data   <= '0;
      r_mean     <= '0;
      r_var      <= '0;
    end else begin
      state      <= state_next;
      settle_2nd <= (state == SETTLE) && !settle_2nd;
      acc_status <= !hs;
      if (hs) acc_data <= s_data;
      if (state == CLEAR) cnt <= '0;
      else if (hs)        cnt <= cnt + CW'(1);
      if (calc_done && !abort) begin
        r_mean <= calc_mean;
        r_var  <= calc_var;
      end
    end
  end

  stats_var_calc #(
    .LOG2_WIN(LOG2_WIN)
  ) u_var_calc (
    .clk       (clk),
    .rst       (reset),
    .start     (calc_start),
    .acc_sum   (acc_sum),
    .acc_sum_sq(acc_sum_sq),
    .done      (calc_done),
    .mean      (calc_mean),
    .variance  (calc_var)
  );

endmodule

// File: tb/tb_stats_window_ctrl.sv
// Bench for stats_window_ctrl: behavioural accumulator/exp models, a window-level reference model, directed and random stimulus.
module tb_stats_window_ctrl;

  localparam int L2  = 2;
  localparam int WIN = 4;
  localparam int VS  = 0;
  localparam int EL  = 6;
`ifdef STATS_EXP_SCORE_EN
  localparam int OUT_LAT = 4 + EL + 1;
`else
  localparam int OUT_LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        r_ready = 1'b0;
  logic        s_ready, acc_mode, acc_status, r_valid, busy;
  logic [15:0] acc_data, exp_in, exp_result, r_mean, r_exp;
  logic [31:0] r_var;
  logic [63:0] acc_sum = 64'h0;
  logic [63:0] acc_sum_sq = 64'h0;
  logic [15:0] epipe[EL];

  int n_cmp = 0;
  int n_bad = 0;

  // window-level reference model state
  bit          m_act = 0;
  int          m_age = 0, m_n = 0, m_since = 0;
  logic [63:0] m_sum = 0, m_sq = 0;
  logic [15:0] m_d = 0, m_pm = 0, m_pe = 0;
  logic [31:0] m_pv = 0;
  bit          m_phs = 0;

  always #5 clk = ~clk;

  stats_window_ctrl #(.LOG2_WIN(L2), .VAR_SHIFT(VS), .EXP_LATENCY(EL)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .acc_mode(acc_mode), .acc_status(acc_status), .acc_data(acc_data),
    .acc_sum(acc_sum), .acc_sum_sq(acc_sum_sq),
    .exp_in(exp_in), .exp_result(exp_result),
    .r_valid(r_valid), .r_ready(r_ready), .r_mean(r_mean), .r_var(r_var), .r_exp(r_exp),
    .busy(busy)
  );

  function automatic logic [15:0] exp_model(input logic [15:0] x);
    int v;
    v = 256 + int'($signed(x));
    if (v < 0) v = 0;
    return 16'(v);
  endfunction

  function automatic logic [15:0] earg(input logic [31:0] v);
    logic [31:0] s;
    s = v >> VS;
    if (s > 32'd1024) s = 32'd1024;
    return 16'(32'd0 - s);
  endfunction

  // accumulator and fixed-latency exp unit seen by the DUT
  always @(posedge clk) begin
    if (!acc_mode) begin
      acc_sum    <= 64'h0;
      acc_sum_sq <= 64'h0;
    end else if (!acc_status) begin
      acc_sum    <= acc_sum + 64'(acc_data);
      acc_sum_sq <= acc_sum_sq + 64'(acc_data) * 64'(acc_data);
    end
    epipe[0] <= exp_in;
    for (int i = 1; i < EL; i++) epipe[i] <= epipe[i-1];
  end
  assign exp_result = exp_model(epipe[EL-1]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // compare process: outputs after each posedge against the model, then advance the model
  initial begin
    bit          e_rdy, e_mode, e_rv, hs;
    logic [15:0] e_ein, mn;
    logic [31:0] msq, mm;
    for (int i = 0; i < EL; i++) epipe[i] = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_s_ready", s_ready, 0);
        check("rst_acc_mode", acc_mode, 0);
        check("rst_acc_status", acc_status, 1);
        check("rst_acc_data", acc_data, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_r_mean", r_mean, 0);
        check("rst_r_var", r_var, 0);
        check("rst_r_exp", r_exp, 0);
        check("rst_exp_in", exp_in, 0);
        m_act = 0; m_phs = 0; m_d = 0; m_pm = 0; m_pv = 0; m_pe = 0;
      end else begin
        e_rdy  = m_act && (m_age >= 1) && (m_n < WIN);
        e_mode = m_act && (m_age >= 1);
        e_rv   = m_act && (m_n == WIN) && (m_since >= OUT_LAT);
        e_ein  = 16'h0;
`ifdef STATS_EXP_SCORE_EN
        if (m_act && (m_n == WIN) && (m_since >= 4) && (m_since <= 4 + EL)) e_ein = earg(m_pv);
`endif
        check("s_ready", s_ready, e_rdy);
        check("acc_mode", acc_mode, e_mode);
        check("busy", busy, m_act);
        check("r_valid", r_valid, e_rv);
        check("acc_status", acc_status, !m_phs);
        check("acc_data", acc_data, m_d);
        check("r_mean", r_mean, m_pm);
        check("r_var", r_var, m_pv);
        check("r_exp", r_exp, m_pe);
        check("exp_in", exp_in, e_ein);

        if (!m_act) begin
          m_phs = 0;
          if (start && !abort) begin
            m_act = 1; m_age = 0; m_n = 0; m_since = 0; m_sum = 0; m_sq = 0;
          end
        end else if (abort) begin
          m_act = 0;
          m_phs = 0;
        end else begin
          hs = s_valid && e_rdy;
          if (m_n == WIN) begin
            m_since++;
            if (m_since == 4) begin
              mn   = 16'(m_sum >> L2);
              msq  = 32'(m_sq >> L2);
              mm   = 32'(mn) * 32'(mn);
              m_pm = mn;
              m_pv = (msq >= mm) ? (msq - mm) : 32'd0;
            end
`ifdef STATS_EXP_SCORE_EN
            if (m_since == OUT_LAT) m_pe = exp_model(earg(m_pv));
`endif
          end
          if (hs) begin
            m_sum = m_sum + 64'(s_data);
            m_sq  = m_sq + 64'(s_data) * 64'(s_data);
            m_n++;
            if (m_n == WIN) m_since = 0;
            m_d = s_data;
          end
          m_phs = hs;
          if (e_rv && r_ready) m_act = 0;
          if (m_age < 2) m_age++;
        end
      end
    end
  end

  task automatic feed(input int n, input logic [15:0] val);
    int k, guard;
    bit h;
    k = 0;
    guard = 0;
    while (k < n && guard < 100) begin
      s_valid = 1'b1;
      s_data  = val;
      h = s_valid && s_ready;
      tick();
      if (h) k++;
      guard++;
    end
    s_valid = 1'b0;
    check("feed_budget", guard < 100, 1);
  endtask

  task automatic run_window(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                            input logic [15:0] s3, input bit gap, input int hold,
                            input logic [15:0] want_mean, input logic [31:0] want_var,
                            input logic [15:0] want_exp);
    logic [15:0] smp[4];
    int k, guard, lat;
    bit h;
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    guard = 0;
    while (k < WIN && guard < 100) begin
      s_valid = !gap || (guard % 2 == 1);
      s_data  = smp[k];
      h = s_valid && s_ready;
      tick();
      if (h) k++;
      guard++;
    end
    s_valid = 1'b0;
    check("hs_budget", guard < 100, 1);
    lat = 0;
    while (!r_valid && lat < 60) begin
      tick();
      lat++;
    end
    check("latency", lat, OUT_LAT);
    repeat (hold) tick();
    check("r_valid_held", r_valid, 1);
    check("lit_r_mean", r_mean, want_mean);
    check("lit_r_var", r_var, want_var);
`ifdef STATS_EXP_SCORE_EN
    check("lit_r_exp", r_exp, want_exp);
`else
    check("lit_r_exp", r_exp, 0);
    if (want_exp == 16'h0) check("lit_exp_arg", want_exp, 0);
`endif
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("idle_after", busy, 0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("init_busy", busy, 0);
    check("init_acc_status", acc_status, 1);

    run_window(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 0, 16'd2, 32'd3, 16'd253);
    run_window(16'd5, 16'd5, 16'd5, 16'd5, 1'b1, 0, 16'd5, 32'd0, 16'd256);
    run_window(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 10, 16'hFFFF, 32'd0, 16'd256);

    // abort mid-window: result registers keep the previous window
    start = 1'b1; tick(); start = 1'b0;
    feed(2, 16'd9);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_acc_mode", acc_mode, 0);
    check("abort_keeps_mean", r_mean, 16'hFFFF);
    run_window(16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 0, 16'd1, 32'd0, 16'd256);

    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);

    // reset in ACCUM
    start = 1'b1; tick(); start = 1'b0;
    feed(2, 16'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_acc_mode", acc_mode, 0);
    check("mid_rst_r_mean", r_mean, 0);
    tick();
    reset = 1'b0;
    tick();
    run_window(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 2, 16'd2, 32'd3, 16'd253);

    for (int c = 0; c < 4000; c++) begin
      start   = ($urandom % 4) == 0;
      abort   = ($urandom % 80) == 0;
      s_valid = ($urandom % 3) != 0;
      s_data  = ($urandom % 2) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535));
      r_ready = ($urandom % 2) == 0;
      reset   = ($urandom % 700) == 0;
      tick();
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; r_ready = 1'b0; reset = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stats_window_ctrl.md
Name: stats_window_ctrl

Overview:
Sequencer for the sum / sum-of-squares accumulator. It accepts a stream of 16-bit unsigned samples over a valid/ready handshake and drives the accumulator's mode, status and data inputs for a window of 2^LOG2_WIN samples. At the end of the window it reads back the 64-bit totals and computes the window mean and variance. It presents the result over a valid/ready handshake to the host interface.

Parameters:
LOG2_WIN, 4, log2 of samples per window (range 1..15)
VAR_SHIFT, 4, right shift applied to variance before exp scoring (optional feature only)
EXP_LATENCY, 6, fixed cycle latency of the exp unit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
start  in  1  pulse; begin a window (ignored unless IDLE)
abort  in  1  pulse; cancel the current window
s_valid  in  1  sample valid
s_data  in  16  sample, unsigned
s_ready  out  1  sample accepted when s_valid&&s_ready
acc_mode  out  1  to accumulator; 0 clears it, 1 enables it
acc_status  out  1  to accumulator; 0 = add acc_data this cycle
acc_data  out  16  to accumulator data input
acc_sum  in  64  accumulator sum
acc_sum_sq  in  64  accumulator sum of squares
exp_in  out  16  signed exponent to exp unit (Q8)
exp_result  in  16  exp unit result (Q8)
r_valid  out  1  result valid
r_ready  in  1  result consumed when r_valid&&r_ready
r_mean  out  16  window mean
r_var  out  32  window variance
r_exp  out  16  exp score
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; outputs acc_mode=0, acc_status=1, acc_data=0, s_ready=0, r_valid=0, r_mean=0, r_var=0, r_exp=0, exp_in=0, busy=0.
- IDLE: acc_mode=0 (accumulator held clear). On start, go to CLEAR.
- CLEAR: 1 cycle with acc_mode=0. Load sample counter with 0. Next state is ACCUM.
- ACCUM:
  - acc_mode=1 and s_ready=1.
  - On a handshake: acc_data<=s_data, acc_status<=0 for exactly the next cycle, counter++. Otherwise acc_status<=1.
  - acc_data and acc_status are registered, so the accumulator adds a sample 1 cycle after its handshake.
  - On the handshake where counter==2^LOG2_WIN-1, s_ready drops the next cycle and the state goes to SETTLE.
- SETTLE: 2 cycles with acc_mode=1 and acc_status=1 after the first. This lets the last sample land in the accumulator.
- CALC1: mean<=acc_sum>>LOG2_WIN, truncated to 16 bits; msq<=acc_sum_sq>>LOG2_WIN, truncated to 32 bits.
- CALC2: var<=msq-mean*mean using 32-bit unsigned arithmetic. If mean*mean>msq, clamp var to 0.
  - Next state is EXP when the optional feature is enabled, otherwise OUT.
- OUT: r_valid=1 with r_mean, r_var and r_exp stable. On r_ready, go to IDLE, drop r_valid, and acc_mode returns to 0.
- Total latency from the last sample handshake to r_valid is 4 cycles without the feature, and 4+EXP_LATENCY+1 with it.
- abort: in any state other than IDLE, go to IDLE next cycle. acc_mode=0, s_ready=0, r_valid=0. Results are not updated.
- abort overrides a same-cycle handshake. The sample is dropped and the sender must treat it as consumed.
- start while busy is ignored. start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- Reset mid-window: immediate return to reset values. The accumulator is cleared by acc_mode=0 on the next clk.
- Counter width is LOG2_WIN+1 bits and has no wrap-around inside a window.

Optional Feature:
- Macro: STATS_EXP_SCORE_EN.
- With it:
  - State EXP drives exp_in = -min(var>>VAR_SHIFT, 1024) as 16-bit signed.
  - exp_in is held for EXP_LATENCY+1 cycles.
  - exp_result is captured into r_exp on the last of those cycles, then the state goes to OUT.
- Without it: no EXP state, exp_in fixed at 0, r_exp fixed at 0, and exp_result is unused.

Decomposition:
- Shared package stats_pkg holds:
  - state enum (IDLE, CLEAR, ACCUM, SETTLE, CALC1, CALC2, EXP, OUT)
  - SAMPLE_W=16, ACC_W=64, VAR_W=32
  - EXP_CLAMP=1024
- One natural sub-module: stats_var_calc, the two-stage mean/variance datapath (CALC1/CALC2) with start/done strobes.
- The FSM, counter and handshakes stay in the top module.

Test Plan:
- LOG2_WIN=2, samples 1,2,3,4 back-to-back, r_ready=1 -> r_mean=2, r_var=3 (msq 30>>2=7, minus 4). r_valid appears 4 cycles after the 4th handshake.
- LOG2_WIN=2, four samples of 5, with s_valid toggling every other cycle -> r_mean=5, r_var=0. acc_status is low only on cycles after handshakes.
- LOG2_WIN=1, samples 0xFFFF,0xFFFF, r_ready held low 10 cycles -> r_mean=0xFFFF, r_var=0. r_valid and data stay stable until r_ready, then IDLE.
- abort after 2 of 4 samples, then start with samples 1,1,1,1 -> r_mean=1, r_var=0. No residue from the aborted window; acc_mode=0 for at least 1 cycle in between.
- reset asserted in ACCUM -> all outputs at reset values the same cycle, and busy=0. start afterwards runs a clean window.
- With STATS_EXP_SCORE_EN and the 6-cycle exp model, samples 5,5,5,5 -> exp_in=0, r_exp=256. With samples 1,2,3,4 and VAR_SHIFT=0 -> exp_in=-3.
